// File: rtl/wave_meas.sv
// Waveform measurement: a Schmitt-trigger level detector delimits cycles on rising
// crossings and reports period, high time and signed peaks of each complete cycle.
module wave_meas #(
    parameter int DataWidth = 16,
    parameter int CntWidth  = 24,
    parameter int Hyst      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        sample_valid,
    input  logic signed [DataWidth-1:0] sample,
    input  logic signed [DataWidth-1:0] threshold,
    output logic        [CntWidth-1:0]  period,
    output logic        [CntWidth-1:0]  high_time,
    output logic signed [DataWidth-1:0] peak_max,
    output logic signed [DataWidth-1:0] peak_min,
    output logic                        meas_valid,
    output logic                        timeout,
    output logic                        dbg_measure,
    output logic                        dbg_level
);

    typedef enum logic {
        SEEK    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic        [CntWidth-1:0] CntMax = '1;
    localparam logic        [CntWidth-1:0] CntOne = CntWidth'(1);
    localparam logic signed [DataWidth:0]  HystX  = (DataWidth+1)'(Hyst);

    state_t                      state, state_d;
    logic                        level, level_d;
    logic        [CntWidth-1:0]  cnt, cnt_d, hcnt, hcnt_d, cnt_inc;
    logic signed [DataWidth-1:0] max_r, max_d, min_r, min_d;
    logic signed [DataWidth:0]   sample_x, thr_hi, thr_lo;
    logic                        rise, capture, set_to;

    // One extra bit so threshold +/- Hyst can never wrap around the sample range.
    assign sample_x = {sample[DataWidth-1], sample};
    assign thr_hi   = {threshold[DataWidth-1], threshold} + HystX;
    assign thr_lo   = {threshold[DataWidth-1], threshold} - HystX;
    assign cnt_inc  = cnt + CntOne;

    // sample_valid qualifies sample: nothing (including level) moves in a cycle where it is low.
    always_comb begin
        level_d = level;
        if (sample_valid) begin
            if (sample_x >= thr_hi)
                level_d = 1'b1;
            else if (sample_x < thr_lo)
                level_d = 1'b0;
        end
    end

    assign rise = sample_valid & ~level & level_d;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        hcnt_d  = hcnt;
        max_d   = max_r;
        min_d   = min_r;
        capture = 1'b0;
        set_to  = 1'b0;
        if (!en) begin
            state_d = SEEK;
            cnt_d   = '0;
            hcnt_d  = '0;
        end else if (sample_valid) begin
            if (rise) begin
                capture = (state == MEASURE);
                state_d = MEASURE;
                cnt_d   = CntOne;
                hcnt_d  = CntOne;
                max_d   = sample;
                min_d   = sample;
            end else if (cnt_inc == CntMax) begin
                set_to  = 1'b1;
                state_d = SEEK;
                cnt_d   = '0;
                hcnt_d  = '0;
            end else begin
                cnt_d = cnt_inc;
                if (state == MEASURE) begin
                    if (level_d)
                        hcnt_d = hcnt + CntOne;
                    if (sample > max_r)
                        max_d = sample;
                    if (sample < min_r)
                        min_d = sample;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SEEK;
            level      <= 1'b0;
            cnt        <= '0;
            hcnt       <= '0;
            max_r      <= '0;
            min_r      <= '0;
            period     <= '0;
            high_time  <= '0;
            peak_max   <= '0;
            peak_min   <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_d;
            level      <= level_d;
            cnt        <= cnt_d;
            hcnt       <= hcnt_d;
            max_r      <= max_d;
            min_r      <= min_d;
            meas_valid <= capture;
            if (capture) begin
                period    <= cnt;
                high_time <= hcnt;
                peak_max  <= max_r;
                peak_min  <= min_r;
            end
            if (!en || capture)
                timeout <= 1'b0;
            else if (set_to)
                timeout <= 1'b1;
        end
    end

    assign dbg_measure = (state == MEASURE);
    assign dbg_level   = level;

endmodule

// File: tb/tb_wave_meas.sv
// Directed bench for wave_meas: square, sine loopback, noise, timeout, valid gaps,
// mid-window reset and enable drop, with hand-computed expectations.
module tb_wave_meas;

    localparam int DW = 16;
    localparam int CW = 8;
    localparam int HY = 16;

    logic                 clk = 1'b0;
    logic                 rst, en, sample_valid;
    logic signed [DW-1:0] sample, threshold;
    logic        [CW-1:0] period, high_time;
    logic signed [DW-1:0] peak_max, peak_min;
    logic                 meas_valid, timeout, dbg_measure, dbg_level;

    int n_assert = 0;
    int n_fail   = 0;
    int mv_cnt   = 0;
    int gap_ctr  = 0;
    int base     = 0;
    bit gaps     = 1'b0;
    int exp_period, exp_high, exp_max, exp_min;

    wave_meas #(.DataWidth(DW), .CntWidth(CW), .Hyst(HY)) dut (
        .clk(clk), .rst(rst), .en(en), .sample_valid(sample_valid),
        .sample(sample), .threshold(threshold),
        .period(period), .high_time(high_time),
        .peak_max(peak_max), .peak_min(peak_min),
        .meas_valid(meas_valid), .timeout(timeout),
        .dbg_measure(dbg_measure), .dbg_level(dbg_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (meas_valid === 1'b1) begin
            mv_cnt++;
            chk("mv_period", int'(period), exp_period);
            chk("mv_high", int'(high_time), exp_high);
            chk("mv_max", int'(peak_max), exp_max);
            chk("mv_min", int'(peak_min), exp_min);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic push(input int v);
        if (gaps) begin
            gap_ctr++;
            if (gap_ctr % 3 == 0) begin
                sample_valid = 1'b0;
                sample       = 16'sh7fff;
                tick();
            end
        end
        sample       = 16'(v);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic square(input int n);
        for (int p = 0; p < n; p++)
            for (int i = 0; i < 32; i++)
                push(i < 10 ? 1000 : -1000);
    endtask

    task automatic disable_low(input int n);
        en           = 1'b0;
        sample       = -16'sd1000;
        sample_valid = 1'b1;
        idle(n);
        sample_valid = 1'b0;
    endtask

    function automatic int quarter(input int k);
        case (k)
            0: return 0;
            1: return 6393;
            2: return 12539;
            3: return 18204;
            4: return 23170;
            5: return 27245;
            6: return 30273;
            7: return 32137;
            default: return 32767;
        endcase
    endfunction

    function automatic int sine(input int i);
        if (i <= 8) return quarter(i);
        if (i <= 16) return quarter(16 - i);
        return -sine(i - 16);
    endfunction

    initial begin
        rst = 1'b0; en = 1'b0; sample_valid = 1'b0; sample = '0; threshold = '0;
        exp_period = 32; exp_high = 10; exp_max = 1000; exp_min = -1000;

        // reset state
        idle(2);
        chk("rst_period", int'(period), 0);
        chk("rst_high", int'(high_time), 0);
        chk("rst_max", int'(peak_max), 0);
        chk("rst_min", int'(peak_min), 0);
        chk("rst_mv", int'(meas_valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_state", int'(dbg_measure), 0);
        chk("rst_level", int'(dbg_level), 0);
        rst = 1'b1;
        en  = 1'b1;
        idle(1);

        // noise inside the hysteresis band
        for (int k = 0; k < 20; k++) push(k % 2 ? -10 : 10);
        chk("noise_mv", mv_cnt, 0);
        chk("noise_level", int'(dbg_level), 0);
        chk("noise_state", int'(dbg_measure), 0);

        // exact hysteresis boundaries
        push(15);
        chk("bnd_15", int'(dbg_level), 0);
        push(16);
        chk("bnd_16", int'(dbg_level), 1);
        chk("bnd_edge_state", int'(dbg_measure), 1);
        push(-16);
        chk("bnd_m16", int'(dbg_level), 1);
        push(-17);
        chk("bnd_m17", int'(dbg_level), 0);
        disable_low(3);
        chk("en0_state", int'(dbg_measure), 0);
        en = 1'b1;

        // square wave
        base = mv_cnt;
        square(3);
        chk("sq_mv_count", mv_cnt - base, 2);
        push(1000);
        chk("sq_mv_pulse", int'(meas_valid), 1);
        chk("sq_mv_total", mv_cnt - base, 3);
        tick();
        chk("sq_mv_single", int'(meas_valid), 0);

        // timeout: edge already taken, constant 500 keeps level high
        repeat (253) push(500);
        chk("to_not_yet", int'(timeout), 0);
        chk("to_state_meas", int'(dbg_measure), 1);
        push(500);
        chk("to_set", int'(timeout), 1);
        chk("to_state_seek", int'(dbg_measure), 0);
        chk("to_hold_period", int'(period), 32);
        chk("to_hold_high", int'(high_time), 10);
        chk("to_hold_max", int'(peak_max), 1000);
        chk("to_hold_min", int'(peak_min), -1000);
        base = mv_cnt;
        square(2);
        chk("to_sticky", int'(timeout), 1);
        chk("to_resume_mv", mv_cnt - base, 0);
        push(1000);
        chk("to_resume_pulse", int'(meas_valid), 1);
        chk("to_cleared", int'(timeout), 0);

        // sample_valid gaps
        disable_low(3);
        en = 1'b1;
        base = mv_cnt;
        gaps = 1'b1;
        square(3);
        push(1000);
        gaps = 1'b0;
        chk("gap_mv_count", mv_cnt - base, 3);
        chk("gap_period", int'(period), 32);
        chk("gap_high", int'(high_time), 10);

        // generator loopback sine
        disable_low(3);
        en = 1'b1;
        exp_period = 32; exp_high = 16; exp_max = 32767; exp_min = -32767;
        base = mv_cnt;
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 32; i++)
                push(sine(i));
        push(sine(0));
        push(sine(1));
        chk("sine_mv_count", mv_cnt - base, 3);
        chk("sine_high", int'(high_time), 16);
        chk("sine_max", int'(peak_max), 32767);

        // reset mid-window
        disable_low(3);
        en = 1'b1;
        exp_period = 32; exp_high = 10; exp_max = 1000; exp_min = -1000;
        square(1);
        for (int i = 0; i < 15; i++) push(i < 10 ? 1000 : -1000);
        chk("mid_period", int'(period), 32);
        rst = 1'b0;
        #1;
        chk("arst_period", int'(period), 0);
        chk("arst_high", int'(high_time), 0);
        chk("arst_max", int'(peak_max), 0);
        chk("arst_min", int'(peak_min), 0);
        chk("arst_state", int'(dbg_measure), 0);
        idle(2);
        rst = 1'b1;
        base = mv_cnt;
        square(1);
        chk("arst_first_edge", mv_cnt - base, 0);
        push(1000);
        chk("arst_second_edge", mv_cnt - base, 1);

        // enable drop mid-window keeps outputs
        for (int i = 1; i < 15; i++) push(i < 10 ? 1000 : -1000);
        disable_low(5);
        chk("en_hold_period", int'(period), 32);
        chk("en_hold_high", int'(high_time), 10);
        chk("en_hold_max", int'(peak_max), 1000);
        chk("en_state", int'(dbg_measure), 0);
        en = 1'b1;
        base = mv_cnt;
        square(1);
        chk("en_first_edge", mv_cnt - base, 0);
        push(1000);
        chk("en_second_edge", mv_cnt - base, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
